// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
// Boot-time sequencer for the system-ID slave. Reads the ID and timestamp
// words over Avalon-MM, compares them against build-time values, retries on
// mismatch, detects a stuck slave, and releases the CPU reset only on a pass.
//
// Ports:
//   clock, reset_n        single clock, synchronous active-low reset
//   start                 re-run request, honoured only in PASS or FAIL
//   avm_address/avm_read  Avalon-MM read master request (registered)
//   avm_readdata          slave data, sampled when avm_waitrequest is low
//   avm_waitrequest       slave stall
//   id_value, ts_value    last captured ID / timestamp words
//   busy, done, pass      status flags
//   fail_code             00 none, 01 ID, 10 timestamp, 11 timeout
//   retry_cnt             retries consumed in the current run
//   cpu_reset_n           CPU reset release, high only in PASS
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd1668940664,
    parameter logic [31:0] EXPECTED_TS = 32'd0,
    parameter logic        CHECK_TS    = 1'b0,
    parameter logic        ID_ADDR     = 1'b1,
    parameter logic        TS_ADDR     = 1'b0,
    parameter logic [7:0]  TIMEOUT     = 8'd255,
    parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [1:0]  retry_cnt,
    output logic        cpu_reset_n
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CODE_W = 2;

    localparam logic [CODE_W-1:0] FC_NONE    = 2'b00;
    localparam logic [CODE_W-1:0] FC_ID      = 2'b01;
    localparam logic [CODE_W-1:0] FC_TS      = 2'b10;
    localparam logic [CODE_W-1:0] FC_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_RD_ID = 3'd0,
        S_RD_TS = 3'd1,
        S_EVAL  = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0]   ts_q, ts_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          retry_q, retry_d;
    logic [CODE_W-1:0]   fail_q, fail_d;
    logic                read_q, read_d;
    logic                addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                cpu_rst_q, cpu_rst_d;

    logic                accept;
    logic                stall;
    logic [WAIT_W:0]     wait_inc;
    logic                id_mis;
    logic                ts_mis;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ts_d      = ts_q;
        wait_d    = wait_q;
        retry_d   = retry_q;
        fail_d    = fail_q;

        // A beat only counts once the request is actually on the bus
        accept    = read_q && !avm_waitrequest;
        stall     = read_q && avm_waitrequest;
        wait_inc  = {1'b0, wait_q} + (WAIT_W+1)'(1);
        id_mis    = (id_q != EXPECTED_ID);
        ts_mis    = CHECK_TS && (ts_q != EXPECTED_TS);

        case (state_q)
            S_RD_ID, S_RD_TS: begin
                if (accept) begin
                    wait_d = '0;
                    if (state_q == S_RD_ID) begin
                        id_d    = avm_readdata;
                        state_d = S_RD_TS;
                    end else begin
                        ts_d    = avm_readdata;
                        state_d = S_EVAL;
                    end
                end else if (stall) begin
                    // Counter reaching TIMEOUT while still stalled ends the run
                    if (wait_inc == {1'b0, TIMEOUT}) begin
                        state_d = S_FAIL;
                        fail_d  = FC_TIMEOUT;
                    end
                    wait_d = wait_inc[WAIT_W-1:0];
                end
            end
            S_EVAL: begin
                if (!id_mis && !ts_mis) begin
                    state_d = S_PASS;
                end else if (retry_q < MAX_RETRY) begin
                    retry_d = retry_q + 2'(1);
                    state_d = S_RD_ID;
                end else begin
                    state_d = S_FAIL;
                    fail_d  = id_mis ? FC_ID : FC_TS;
                end
            end
            S_PASS, S_FAIL: begin
                if (start) begin
                    state_d = S_RD_ID;
                    retry_d = '0;
                    fail_d  = FC_NONE;
                    wait_d  = '0;
                end
            end
            default: state_d = S_RD_ID;
        endcase

        // Outputs follow the state being entered so they are registered with it
        read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        addr_d    = (state_d == S_RD_TS) ? TS_ADDR : ID_ADDR;
        busy_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS) || (state_d == S_EVAL);
        done_d    = (state_d == S_PASS) || (state_d == S_FAIL);
        pass_d    = (state_d == S_PASS);
        cpu_rst_d = (state_d == S_PASS);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_RD_ID;
            id_q      <= '0;
            ts_q      <= '0;
            wait_q    <= '0;
            retry_q   <= '0;
            fail_q    <= FC_NONE;
            read_q    <= 1'b0;
            addr_q    <= ID_ADDR;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            wait_q    <= wait_d;
            retry_q   <= retry_d;
            fail_q    <= fail_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_q;
    assign retry_cnt   = retry_q;
    assign cpu_reset_n = cpu_rst_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Testbench for sysid_boot_checker. dut0 uses default parameters against a
// configurable slave model; dut1 checks the timestamp (EXPECTED_TS=5) against
// a slave returning timestamp 0. Expected run results are queued by the
// stimulus and compared by per-DUT monitors when done rises.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd1668940664;
    localparam logic [31:0] BAD_ID = 32'h12345678;

    typedef struct {
        logic        pass;
        logic [1:0]  fc;
        logic [1:0]  rc;
        logic [31:0] id;
        logic [31:0] ts;
        int          lat;
        int          stalls;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0_n, reset1_n, start;
    int   bad_n, stall_n;

    logic        addr0, read0, wait0, busy0, done0, pass0, cpu0;
    logic [31:0] rdata0, id0, ts0;
    logic [1:0]  fc0, rc0;
    logic        addr1, read1, wait1, busy1, done1, pass1, cpu1;
    logic [31:0] rdata1, id1, ts1;
    logic [1:0]  fc1, rc1;

    int id_reads0 = 0;
    int stalls0   = 0;
    int cyc0      = 0;
    int cyc1      = 0;

    sysid_boot_checker dut0 (
        .clock(clk), .reset_n(reset0_n), .start(start),
        .avm_address(addr0), .avm_read(read0),
        .avm_readdata(rdata0), .avm_waitrequest(wait0),
        .id_value(id0), .ts_value(ts0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_code(fc0), .retry_cnt(rc0), .cpu_reset_n(cpu0)
    );

    sysid_boot_checker #(.CHECK_TS(1'b1), .EXPECTED_TS(32'd5)) dut1 (
        .clock(clk), .reset_n(reset1_n), .start(start),
        .avm_address(addr1), .avm_read(read1),
        .avm_readdata(rdata1), .avm_waitrequest(wait1),
        .id_value(id1), .ts_value(ts1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_code(fc1), .retry_cnt(rc1), .cpu_reset_n(cpu1)
    );

    // Slave models: dut0 stalls its first stall_n read cycles and returns a
    // bad ID for its first bad_n ID reads; dut1 is a clean zero-wait slave.
    assign wait0  = read0 && (stalls0 < stall_n);
    assign rdata0 = (addr0 == 1'b1) ? ((id_reads0 < bad_n) ? BAD_ID : EXP_ID) : 32'd0;
    assign wait1  = 1'b0;
    assign rdata1 = (addr1 == 1'b1) ? EXP_ID : 32'd0;

    always @(posedge clk) begin
        if (!reset0_n || start) begin
            id_reads0 <= 0;
            stalls0   <= 0;
            cyc0      <= 0;
        end else begin
            cyc0 <= cyc0 + 1;
            if (read0 && wait0) stalls0 <= stalls0 + 1;
            if (read0 && !wait0 && addr0) id_reads0 <= id_reads0 + 1;
        end
        if (!reset1_n || start) cyc1 <= 0;
        else                    cyc1 <= cyc1 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic cmp_result(input string tag, input exp_t e, input logic p, input logic cpu,
                              input logic [1:0] fc, input logic [1:0] rc,
                              input logic [31:0] id, input logic [31:0] ts,
                              input int lat, input int stalls);
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
        chk({tag, "_cpu_reset_n"}, 32'(cpu), 32'(e.pass));
        chk({tag, "_fail_code"}, 32'(fc), 32'(e.fc));
        chk({tag, "_retry_cnt"}, 32'(rc), 32'(e.rc));
        chk({tag, "_id_value"}, id, e.id);
        chk({tag, "_ts_value"}, ts, e.ts);
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
    endtask

    // Monitors: compare a queued result whenever done rises
    logic prev_done0 = 1'b0;
    logic prev_done1 = 1'b0;
    logic prev_stall0 = 1'b0;
    logic prev_addr0 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done0 && !prev_done0) begin
            chk("sb0_pending", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp_result("dut0", e, pass0, cpu0, fc0, rc0, id0, ts0, cyc0, stalls0);
            end
        end
        if (done1 && !prev_done1) begin
            chk("sb1_pending", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp_result("dut1", e, pass1, cpu1, fc1, rc1, id1, ts1, cyc1, 0);
            end
        end
        // Request must hold steady across a stall unless the run just timed out
        if (prev_stall0 && !done0 && reset0_n) begin
            chk("stall_read_hold", 32'(read0), 32'd1);
            chk("stall_addr_hold", 32'(addr0), 32'(prev_addr0));
        end
        prev_done0  = done0;
        prev_done1  = done1;
        prev_stall0 = read0 && wait0;
        prev_addr0  = addr0;
    end

    task automatic wait_done0(input int budget);
        int n = 0;
        while (!done0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("dut0_done_within_budget", 32'(done0), 32'd1);
    endtask

    task automatic wait_done1(input int budget);
        int n = 0;
        while (!done1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("dut1_done_within_budget", 32'(done1), 32'd1);
    endtask

    task automatic restart0();
        reset0_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset0_n = 1'b1;
    endtask

    initial begin
        reset0_n = 1'b0;
        reset1_n = 1'b0;
        start    = 1'b0;
        bad_n    = 0;
        stall_n  = 0;
        repeat (3) @(negedge clk);

        chk("rst_id_value",    id0, 32'd0);
        chk("rst_ts_value",    ts0, 32'd0);
        chk("rst_retry_cnt",   32'(rc0), 32'd0);
        chk("rst_fail_code",   32'(fc0), 32'd0);
        chk("rst_cpu_reset_n", 32'(cpu0), 32'd0);
        chk("rst_pass",        32'(pass0), 32'd0);
        chk("rst_done",        32'(done0), 32'd0);
        chk("rst_avm_read",    32'(read0), 32'd0);

        // Zero-wait clean slave
        q0.push_back('{1'b1, 2'b00, 2'd0, EXP_ID, 32'd0, 4, 0});
        reset0_n = 1'b1;
        wait_done0(50);

        // Five stall cycles on the ID read
        stall_n = 5;
        q0.push_back('{1'b1, 2'b00, 2'd0, EXP_ID, 32'd0, 9, 5});
        restart0();
        wait_done0(50);
        stall_n = 0;

        // Two bad ID reads, then good
        bad_n = 2;
        q0.push_back('{1'b1, 2'b00, 2'd2, EXP_ID, 32'd0, 10, 0});
        restart0();
        wait_done0(50);

        // ID always wrong: fail after three retries
        bad_n = 100;
        q0.push_back('{1'b0, 2'b01, 2'd3, BAD_ID, 32'd0, 13, 0});
        restart0();
        wait_done0(80);
        repeat (10) @(negedge clk);
        chk("fail_hold_cpu_reset_n", 32'(cpu0), 32'd0);
        chk("fail_hold_done",        32'(done0), 32'd1);
        chk("fail_hold_fail_code",   32'(fc0), 32'd1);

        // Re-run with start and a clean slave
        bad_n = 0;
        q0.push_back('{1'b1, 2'b00, 2'd0, EXP_ID, 32'd0, 3, 0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_done",  32'(done0), 32'd0);
        chk("start_clears_fc",    32'(fc0), 32'd0);
        chk("start_clears_rc",    32'(rc0), 32'd0);
        chk("start_keeps_id",     id0, BAD_ID);
        chk("start_issues_read",  32'(read0), 32'd1);
        wait_done0(50);

        // Stuck slave: timeout, no retry
        stall_n = 1000;
        q0.push_back('{1'b0, 2'b11, 2'd0, 32'd0, 32'd0, 256, 255});
        restart0();
        wait_done0(400);
        repeat (10) @(negedge clk);
        chk("timeout_read_dropped", 32'(read0), 32'd0);
        chk("timeout_no_retry",     32'(rc0), 32'd0);
        stall_n = 0;

        // dut1: timestamp mismatch fails with code 10
        q1.push_back('{1'b0, 2'b10, 2'd3, EXP_ID, 32'd0, 13, 0});
        reset1_n = 1'b1;
        wait_done1(80);

        // Reset pulsed during the timestamp read
        reset1_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset1_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("dut1_in_rd_ts_addr", 32'(addr1), 32'd0);
        chk("dut1_in_rd_ts_read", 32'(read1), 32'd1);
        chk("dut1_in_rd_ts_id",   id1, EXP_ID);
        reset1_n = 1'b0;
        @(negedge clk);
        chk("midrst_avm_read",    32'(read1), 32'd0);
        chk("midrst_id_value",    id1, 32'd0);
        chk("midrst_ts_value",    ts1, 32'd0);
        chk("midrst_retry_cnt",   32'(rc1), 32'd0);
        chk("midrst_fail_code",   32'(fc1), 32'd0);
        chk("midrst_cpu_reset_n", 32'(cpu1), 32'd0);
        chk("midrst_done",        32'(done1), 32'd0);
        chk("midrst_busy",        32'(busy1), 32'd1);
        q1.push_back('{1'b0, 2'b10, 2'd3, EXP_ID, 32'd0, 13, 0});
        reset1_n = 1'b1;
        wait_done1(80);

        repeat (3) @(negedge clk);
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
